pipe_seg_buf: RTL and testbench

PIPE_SEG_BUF -- requirements
Module: pipe_seg_buf

---
 rtl/pipe_seg_buf.sv | 144 ++++++++++++++
 tb/tb_pipe_seg_buf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipe_seg_buf : registered pipeline segment buffer with flush.          |
// | Define PIPE_SEG_SKID_EN for a 2-entry skid buffer (registered in_ready)|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module pipe_seg_buf #(
  parameter int WIDTH       = 64,
  parameter int CLR_PAYLOAD = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic c_clr = (CLR_PAYLOAD != 0);

  logic [WIDTH-1:0] r_main;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_data   = r_main;

`ifdef PIPE_SEG_SKID_EN
  // State encoding doubles as the occupancy count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_skid;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_next_state   = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_next_state = S_TWO;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_next_state     = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase
    if (flush) begin
      w_next_state = S_EMPTY;
    end
  end

  always_comb begin
    out_valid = (r_state != S_EMPTY);
    in_ready  = (r_state != S_TWO);
    occupancy = r_state;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      if (c_clr) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end
`else
  logic r_valid;

  // Accept when empty or when the held entry leaves this same cycle.
  assign in_ready  = !r_valid | out_ready;
  assign out_valid = r_valid;
  assign occupancy = {1'b0, r_valid};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      if (c_clr) begin
        r_main <= '0;
      end
    end else if (w_in_fire) begin
      r_main <= in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_seg_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipe_seg_buf : directed bench with queue scoreboard for pipe_seg_buf|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_pipe_seg_buf;

  localparam int WIDTH = 64;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int               n_cmp;
  int               n_fail;
  logic             mon_en;
  logic [WIDTH-1:0] sb[$];

  pipe_seg_buf #(.WIDTH(WIDTH), .CLR_PAYLOAD(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: state after each edge must match the queue built from the handshakes before it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!resetn) begin
        sb.delete();
      end else begin
        check("sb_occupancy", 64'(occupancy), 64'(sb.size()));
        check("sb_out_valid", 64'(out_valid), 64'(sb.size() != 0));
`ifdef PIPE_SEG_SKID_EN
        check("sb_in_ready", 64'(in_ready), 64'(sb.size() != 2));
`else
        check("sb_in_ready", 64'(in_ready), 64'((sb.size() == 0) || out_ready));
`endif
        if (out_valid && out_ready && sb.size() != 0) begin
          check("sb_out_data", out_data, sb.pop_front());
        end
        if (flush) begin
          sb.delete();
        end else if (in_valid && in_ready) begin
          sb.push_back(in_data);
        end
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    mon_en    = 1'b0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle
    tick(); tick(); tick();
    resetn = 1'b1;
    mon_en = 1'b1;
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", out_data, 64'd0);

    // Streaming 1,2,3 with no bubbles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    tick();
    check("strm_v1", 64'(out_valid), 64'd1);
    check("strm_d1", out_data, 64'h1);
    in_data = 64'h2;
    tick();
    check("strm_v2", 64'(out_valid), 64'd1);
    check("strm_d2", out_data, 64'h2);
    in_data = 64'h3;
    tick();
    check("strm_v3", 64'(out_valid), 64'd1);
    check("strm_d3", out_data, 64'h3);
    in_valid = 1'b0;
    tick();
    check("strm_drain", 64'(out_valid), 64'd0);

`ifdef PIPE_SEG_SKID_EN
    // Backpressure fills main and skid, third entry held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    check("bp_occ2", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_data = 64'hC;
    tick();
    check("bp_hold_occ", 64'(occupancy), 64'd2);
    check("bp_hold_data", out_data, 64'hA);
    out_ready = 1'b1;
    tick();
    check("bp_d_b", out_data, 64'hB);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("bp_d_c", out_data, 64'hC);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(occupancy), 64'd0);
`else
    // Single register: stall blocks upstream, release replaces in place
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    tick();
    in_data = 64'h22;
    check("ns_stall_ready", 64'(in_ready), 64'd0);
    tick();
    check("ns_hold_data", out_data, 64'h11);
    check("ns_hold_occ", 64'(occupancy), 64'd1);
    out_ready = 1'b1;
    #1;
    check("ns_release_ready", 64'(in_ready), 64'd1);
    tick();
    check("ns_replace_data", out_data, 64'h22);
    check("ns_replace_occ", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    check("ns_empty", 64'(occupancy), 64'd0);
`endif

    // Flush while full, 0xD offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h5;
    tick();
    in_data = 64'h6;
    tick();
    flush   = 1'b1;
    in_data = 64'hD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_full_occ", 64'(occupancy), 64'd0);
    check("fl_full_valid", 64'(out_valid), 64'd0);
    check("fl_full_data", out_data, 64'd0);

    // Flush with an out_fire and an in_fire of 0xD in the same cycle
    in_valid = 1'b1;
    in_data  = 64'h7;
    tick();
    out_ready = 1'b1;
    flush     = 1'b1;
    in_data   = 64'hD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_fire_occ", 64'(occupancy), 64'd0);
    check("fl_fire_data", out_data, 64'd0);
    tick(); tick();
    check("fl_no_d", 64'(out_valid), 64'd0);

    // Reset mid-stream drops the held entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h9;
    tick();
    check("mr_occ1", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    resetn   = 1'b0;
    tick();
    resetn = 1'b1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_occ", 64'(occupancy), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    check("mr_no_deliver", 64'(out_valid), 64'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
